log_norm: RTL and testbench

LOG_NORM -- requirements
Module: log_norm

---
 rtl/log_norm.sv | 93 +++++++++
 tb/tb_log_norm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/log_norm.sv
// Normalizes an unsigned magnitude to an MSB-aligned mantissa plus floor(log2) exponent.
// Optional output zero_flag is enabled by defining LOG_NORM_ZERO_FLAG_EN.
module log_norm #(
  parameter int IN_WIDTH    = 16,
  parameter int NORM_WIDTH  = 16,
  parameter int SHIFT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NORM_WIDTH-1:0]  data_out,
  output logic [SHIFT_WIDTH-1:0] shift_amt
`ifdef LOG_NORM_ZERO_FLAG_EN
  ,
  output logic                   zero_flag
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DETECT = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [1:0] SEND   = 2'd3;

  logic [1:0]             state;
  logic [IN_WIDTH-1:0]    cap_p0;
  logic [SHIFT_WIDTH-1:0] msb_p1;

  // Highest set bit wins; an all-zero word reports index 0.
  function automatic logic [SHIFT_WIDTH-1:0] msb_index(input logic [IN_WIDTH-1:0] v);
    logic [SHIFT_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (v[i]) idx = SHIFT_WIDTH'(i);
    end
    return idx;
  endfunction

  function automatic logic [NORM_WIDTH-1:0] normalize(input logic [IN_WIDTH-1:0]    v,
                                                      input logic [SHIFT_WIDTH-1:0] m);
    logic [IN_WIDTH-1:0] s;
    s = v << (IN_WIDTH - 1 - int'(m));
    return s[IN_WIDTH-1 -: NORM_WIDTH];
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cap_p0    <= '0;
      msb_p1    <= '0;
      data_out  <= '0;
      shift_amt <= '0;
`ifdef LOG_NORM_ZERO_FLAG_EN
      zero_flag <= 1'b0;
`endif
    end else begin
      case (state)
        // p0: capture the raw sample
        IDLE: begin
          if (in_valid) begin
            cap_p0 <= data_in;
            state  <= DETECT;
          end
        end
        // p1: priority-encode the exponent
        DETECT: begin
          msb_p1 <= msb_index(cap_p0);
          state  <= SHIFT;
        end
        // p2: align mantissa and publish the result
        SHIFT: begin
          data_out  <= normalize(cap_p0, msb_p1);
          shift_amt <= msb_p1;
`ifdef LOG_NORM_ZERO_FLAG_EN
          zero_flag <= (cap_p0 == '0);
`endif
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_norm.sv
// Randomized and directed bench for log_norm against a plain-arithmetic reference model.
module tb_log_norm;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic [3:0]  shift_amt;
`ifdef LOG_NORM_ZERO_FLAG_EN
  logic        zero_flag;
`endif

  int checks = 0;
  int errors = 0;

  log_norm #(.IN_WIDTH(16), .NORM_WIDTH(16), .SHIFT_WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .shift_amt(shift_amt)
`ifdef LOG_NORM_ZERO_FLAG_EN
    ,
    .zero_flag(zero_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // floor(log2 x) found by repeated halving; mantissa = x * 2^(15-e) truncated to 16 bits.
  task automatic ref_norm(input logic [15:0] x, output logic [15:0] m, output logic [3:0] e);
    int     ei;
    longint prod;
    ei = 0;
    if (x == 16'd0) begin
      m = 16'd0;
      e = 4'd0;
    end else begin
      while ((int'(x) >> (ei + 1)) != 0) ei++;
      prod = longint'(x) * (longint'(1) << (15 - ei));
      m = prod[15:0];
      e = ei[3:0];
    end
  endtask

  // Drives one sample from IDLE and returns what the output port showed and after how many edges.
  task automatic run_sample(input logic [15:0] x, input int stall,
                            output logic [15:0] d, output logic [3:0] s, output int lat);
    in_valid  = 1'b1;
    data_in   = x;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    d = data_out;
    s = shift_amt;
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; data_in = 16'h0; out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || data_out !== 16'h0 || shift_amt !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h shift=%0d, want 0/0000/0",
               out_valid, data_out, shift_amt);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vals [4];
    logic [15:0] d, em;
    logic [3:0]  s, ee;
    int lat;
    vals[0] = 16'h0001; vals[1] = 16'h00F0; vals[2] = 16'hFFFF; vals[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      ref_norm(vals[i], em, ee);
      run_sample(vals[i], 0, d, s, lat);
      checks++;
      if (d !== em || s !== ee || lat != 3) begin
        errors++;
        $display("FAIL directed_%h: got data=%h shift=%0d lat=%0d, want data=%h shift=%0d lat=3",
                 vals[i], d, s, lat, em, ee);
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed_release_%h: got valid=%b ready=%b, want 0/1",
                 vals[i], out_valid, in_ready);
      end
`ifdef LOG_NORM_ZERO_FLAG_EN
      checks++;
      if (zero_flag !== (vals[i] == 16'h0)) begin
        errors++;
        $display("FAIL zero_flag_%h: got %b want %b", vals[i], zero_flag, vals[i] == 16'h0);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; data_in = 16'h1234; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'h91A0 || shift_amt !== 4'd12) begin
      errors++;
      $display("FAIL bp_arrive: got valid=%b data=%h shift=%0d, want 1/91a0/12",
               out_valid, data_out, shift_amt);
    end
    // A competing sample offered during the stall must not be taken.
    in_valid = 1'b1; data_in = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || data_out !== 16'h91A0 || shift_amt !== 4'd12 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b data=%h shift=%0d ready=%b, want 1/91a0/12/0",
                 c, out_valid, data_out, shift_amt, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [24];
    logic [15:0] got_d [$];
    logic [3:0]  got_s [$];
    logic [15:0] em;
    logic [3:0]  ee;
    for (int c = 0; c < 24; c++) vals[c] = 16'($urandom) >> $urandom_range(0, 15);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 24; c++) begin
      data_in = vals[c];
      tick();
      if (out_valid) begin
        got_d.push_back(data_out);
        got_s.push_back(shift_amt);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (got_d.size() != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, want 6", got_d.size());
    end
    for (int k = 0; k < 6 && k < got_d.size(); k++) begin
      ref_norm(vals[4 * k], em, ee);
      checks++;
      if (got_d[k] !== em || got_s[k] !== ee) begin
        errors++;
        $display("FAIL b2b_result_%0d: got data=%h shift=%0d, want data=%h shift=%0d",
                 k, got_d[k], got_s[k], em, ee);
      end
    end
  endtask

  task automatic test_reset_in_shift();
    bit seen;
    in_valid = 1'b1; data_in = 16'h0ABC; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_shift: got valid=%b data=%h ready=%b, want 0/0000/1",
               out_valid, data_out, in_ready);
    end
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_shift_discard: got an emitted result, want none");
    end
  endtask

  task automatic test_random();
    logic [15:0] x, d, em;
    logic [3:0]  s, ee;
    int lat, stall;
    for (int i = 0; i < 20; i++) begin
      x = 16'($urandom) >> $urandom_range(0, 16);
      stall = $urandom_range(0, 3);
      ref_norm(x, em, ee);
      run_sample(x, stall, d, s, lat);
      checks++;
      if (d !== em || s !== ee || lat != 3) begin
        errors++;
        $display("FAIL random_%0d x=%h: got data=%h shift=%0d lat=%0d, want data=%h shift=%0d lat=3",
                 i, x, d, s, lat, em, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_in_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
